// File: rtl/interface_wheel_quad.sv
`default_nettype none
// ============================================================================
// Module  : interface_wheel_quad
// Purpose : Quadrature wheel-encoder interface. Synchronises the two encoder
//           phases, decodes them into a signed position and a per-window
//           step count, and reports saturated speed magnitude, direction,
//           a per-window valid strobe and a sticky illegal-transition flag.
// Revision: 1.0 - initial release
// ============================================================================
module interface_wheel_quad #(
  parameter int CNT_W       = 4,
  parameter int POS_W       = 16,
  parameter int WINDOW      = 50000,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             clear,
  input  logic             enc_a,
  input  logic             enc_b,
  output logic [CNT_W-1:0] count,
  output logic             CW,
  output logic             CWW,
  output logic [POS_W-1:0] position,
  output logic             valid,
  output logic             err
);

  // Window delta carries two extra bits so it can hold more than the
  // reported magnitude range before its own saturation kicks in.
  localparam int c_D_W = CNT_W + 2;
  localparam int c_T_W = $clog2(WINDOW);

  localparam logic signed [c_D_W-1:0] c_D_MAX  = {1'b0, {(CNT_W+1){1'b1}}};
  localparam logic signed [c_D_W-1:0] c_D_MIN  = {1'b1, {CNT_W{1'b0}}, 1'b1};
  localparam logic signed [c_D_W-1:0] c_D_ONE  = {{(c_D_W-1){1'b0}}, 1'b1};
  localparam logic        [c_T_W-1:0] c_T_LAST = c_T_W'(WINDOW - 1);
  localparam logic        [c_T_W-1:0] c_T_ONE  = {{(c_T_W-1){1'b0}}, 1'b1};
  localparam logic        [POS_W-1:0] c_P_ONE  = {{(POS_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  state_t                   r_state;
  logic [SYNC_STAGES-1:0]   r_a_sync;
  logic [SYNC_STAGES-1:0]   r_b_sync;
  logic [1:0]               r_prev_ab;
  logic [c_T_W-1:0]         r_timer;
  logic signed [c_D_W-1:0]  r_delta;
  logic [POS_W-1:0]         r_pos;
  logic [CNT_W-1:0]         r_count;
  logic                     r_cw;
  logic                     r_valid;
  logic                     r_err;

  logic [1:0]               w_ab;
  logic                     w_inc;
  logic                     w_dec;
  logic                     w_bad;
  logic                     w_terminal;
  logic signed [c_D_W-1:0]  w_delta_nxt;
  logic [c_D_W-1:0]         w_mag;
  logic [CNT_W-1:0]         w_sat_cnt;

  // Bring both asynchronous encoder phases into the clk domain.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_a_sync <= '0;
      r_b_sync <= '0;
    end else begin
      r_a_sync <= {r_a_sync[SYNC_STAGES-2:0], enc_a};
      r_b_sync <= {r_b_sync[SYNC_STAGES-2:0], enc_b};
    end
  end

  assign w_ab       = {r_a_sync[SYNC_STAGES-1], r_b_sync[SYNC_STAGES-1]};
  assign w_terminal = (r_timer == c_T_LAST);

  // Gray-code step decode: forward sequence 00-01-11-10, both bits flipping is illegal.
  always_comb begin
    w_inc = 1'b0;
    w_dec = 1'b0;
    w_bad = 1'b0;
    case ({r_prev_ab, w_ab})
      4'b0001, 4'b0111, 4'b1110, 4'b1000: w_inc = 1'b1;
      4'b0010, 4'b1011, 4'b1101, 4'b0100: w_dec = 1'b1;
      4'b0011, 4'b1100, 4'b0110, 4'b1001: w_bad = 1'b1;
      default: ;
    endcase
  end

  // Saturating window delta including this cycle's step, and its clipped magnitude.
  always_comb begin
    w_delta_nxt = r_delta;
    if (w_inc && (r_delta != c_D_MAX)) begin
      w_delta_nxt = r_delta + c_D_ONE;
    end else if (w_dec && (r_delta != c_D_MIN)) begin
      w_delta_nxt = r_delta - c_D_ONE;
    end
    w_mag     = w_delta_nxt[c_D_W-1] ? (-w_delta_nxt) : w_delta_nxt;
    w_sat_cnt = (|w_mag[c_D_W-1:CNT_W]) ? {CNT_W{1'b1}} : w_mag[CNT_W-1:0];
  end

  // Control FSM with decode, position, window timer and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_prev_ab <= 2'b00;
      r_timer   <= '0;
      r_delta   <= '0;
      r_pos     <= '0;
      r_count   <= '0;
      r_cw      <= 1'b1;
      r_valid   <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (clear) begin
        // Clear restarts through ARM so the next decode has a fresh reference.
        r_pos   <= '0;
        r_delta <= '0;
        r_timer <= '0;
        r_err   <= 1'b0;
        r_state <= enable ? ST_ARM : ST_IDLE;
      end else begin
        case (r_state)
          ST_IDLE: begin
            r_timer <= '0;
            if (enable) begin
              r_state <= ST_ARM;
            end
          end
          ST_ARM: begin
            // Capture the current phase pair so enabling never counts a step.
            r_prev_ab <= w_ab;
            r_timer   <= '0;
            r_state   <= enable ? ST_RUN : ST_IDLE;
          end
          ST_RUN: begin
            if (!enable) begin
              // Partial window is discarded; reported outputs hold.
              r_state <= ST_IDLE;
              r_timer <= '0;
              r_delta <= '0;
            end else begin
              r_prev_ab <= w_ab;
              if (w_bad) begin
                r_err <= 1'b1;
              end
              if (w_inc) begin
                r_pos <= r_pos + c_P_ONE;
              end else if (w_dec) begin
                r_pos <= r_pos - c_P_ONE;
              end
              if (w_terminal) begin
                r_count <= w_sat_cnt;
                r_cw    <= ~w_delta_nxt[c_D_W-1];
                r_valid <= 1'b1;
                r_delta <= '0;
                r_timer <= '0;
              end else begin
                r_delta <= w_delta_nxt;
                r_timer <= r_timer + c_T_ONE;
              end
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign count    = r_count;
  assign CW       = r_cw;
  assign CWW      = ~r_cw;
  assign position = r_pos;
  assign valid    = r_valid;
  assign err      = r_err;

endmodule
`default_nettype wire
